// File: rtl/digit_serial_receiver.sv
// Digit-timing receive end: checks the one-hot digit sequence, assembles serial bits
// into a parallel word, and offers each completed word on a valid/ready handshake.
module digit_serial_receiver #(
  parameter int unsigned DIGITS    = 36,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIGITS-1:0] digit_strobe,
  input  logic              serial_in,
  input  logic              enable,
  output logic [DIGITS-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              sync_err,
  output logic              overrun,
  output logic [5:0]        digit_idx
);

  localparam int unsigned   IW   = 6;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic {HUNT, ASM} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     exp_q, exp_d;
  logic [DIGITS-1:0] sreg_q, sreg_d;
  logic [DIGITS-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              sync_err_q, sync_err_d;
  logic              overrun_q, overrun_d;

  logic [IW-1:0]     exp_pos;
  logic [DIGITS-1:0] exp_mask, zero_mask, base;
  logic              hit_exp, hit_zero, complete, xfer;

  // Word bit positions for the expected digit and for digit 0
  assign exp_pos   = LSB_FIRST ? exp_q : LAST - exp_q;
  assign exp_mask  = DIGITS'(1) << exp_pos;
  assign zero_mask = LSB_FIRST ? DIGITS'(1) : (DIGITS'(1) << LAST);

  assign hit_exp  = (digit_strobe == (DIGITS'(1) << exp_q));
  assign hit_zero = (digit_strobe == DIGITS'(1));
  assign xfer     = valid_q && word_ready;
  // Digit 0 always starts a fresh word
  assign base     = (exp_q == '0) ? '0 : sreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      exp_q      <= '0;
      sreg_q     <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      sreg_q     <= sreg_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    sreg_d     = sreg_q;
    word_d     = word_q;
    valid_d    = valid_q;
    sync_err_d = 1'b0;
    overrun_d  = 1'b0;
    complete   = 1'b0;

    if (!enable) begin
      state_d = HUNT;
      exp_d   = '0;
      sreg_d  = '0;
    end else if (state_q == ASM && hit_exp) begin
      sreg_d   = serial_in ? (base | exp_mask) : (base & ~exp_mask);
      complete = (exp_q == LAST);
      exp_d    = complete ? '0 : exp_q + IW'(1);
    end else begin
      // A mismatch in ASM is flagged, then the strobe is re-judged as in HUNT
      sync_err_d = (state_q == ASM);
      if (hit_zero) begin
        state_d = ASM;
        exp_d   = IW'(1);
        sreg_d  = serial_in ? zero_mask : '0;
      end else begin
        state_d = HUNT;
        exp_d   = '0;
        sreg_d  = '0;
      end
    end

    // Output holding register: a completion with an unconsumed word is dropped
    if (complete) begin
      if (!valid_q || xfer) begin
        word_d  = sreg_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign sync_err   = sync_err_q;
  assign overrun    = overrun_q;
  assign digit_idx  = exp_q;

endmodule

// File: doc/digit_serial_receiver.md
Name: digit_serial_receiver

Overview:
- Receive end of the digit-timing protocol. Consumes the 36-phase one-hot digit timing vector and a serial data line, one bit per digit time.
- Checks that the digit sequence is well-formed and assembles each minor cycle's serial bits into a parallel word.
- Presents each completed word on a valid/ready handshake to downstream store/arithmetic logic.
- Detects loss of digit synchronisation and output overrun.

Parameters:
- DIGITS, 36, digit positions per minor cycle and word width. Legal range 2..64.
- LSB_FIRST, 1. When 1, digit k is written to word bit k. When 0, digit k is written to word bit DIGITS-1-k.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digit_strobe  input  DIGITS  ungated one-hot digit timing. Bit k is high for exactly one full clk period during digit k. The clk-gated pulse form must not be connected here.
- serial_in  input  1  serial data bit for the current digit, sampled with digit_strobe.
- enable  input  1  receive enable.
- word  output  DIGITS  last completed word.
- word_valid  output  1  word holds an unconsumed word.
- word_ready  input  1  consumer accepts word.
- sync_err  output  1  one-cycle pulse on a digit sequence violation.
- overrun  output  1  one-cycle pulse when a completed word is dropped.
- digit_idx  output  6  next expected digit index.

Behaviour:
- Reset (async assert, sync release): state HUNT; exp=0; shift register=0.
- Output reset values: word=0, word_valid=0, sync_err=0, overrun=0, digit_idx=0.
- Strobe classes: "onehot(k)" means exactly bit k set. "bad" means zero or more than one bit set.
- HUNT state:
  - digit_idx=0; no sync_err is raised in this state.
  - If enable and strobe==onehot(0): capture serial_in into bit position for digit 0, set exp=1, go to ASM.
  - Any other strobe: remain in HUNT.
- ASM state:
  - If enable and strobe==onehot(exp): capture serial_in into the bit position for digit exp. Set exp=exp+1, wrapping DIGITS-1 to 0. Stay in ASM.
  - Back-to-back minor cycles are seamless: digit DIGITS-1 is followed directly by digit 0.
  - Mismatch (bad, or onehot(j) with j != exp): pulse sync_err for one cycle and discard the partial word.
    - The same strobe is then evaluated as in HUNT. If it is onehot(0), bit 0 is captured and the next state is ASM with exp=1.
    - Otherwise the next state is HUNT.
- enable low in any state:
  - Next state HUNT; partial word discarded; no sync_err.
  - The pending output word and word_valid are unaffected.
- Completion:
  - Occurs on the edge that captures digit DIGITS-1 in ASM.
  - The assembled word, including the bit captured on that edge, is the candidate output.
  - word_valid rises on that same edge, i.e. it is visible in the cycle after the digit DIGITS-1 strobe cycle.
- Handshake:
  - A transfer happens at an edge where word_valid && word_ready.
  - word must be stable while word_valid=1.
  - Transfer and completion on the same edge: load the new word; word_valid stays 1.
  - Transfer only: word_valid goes to 0; word keeps its last value.
  - Completion with word_valid=1 and no transfer: the new word is dropped, the old word is kept, and overrun pulses for one cycle.
- word_ready is ignored while word_valid=0.
- digit_idx reflects exp, zero-extended to 6 bits.
- Reset asserted mid-word: everything returns to reset values immediately. Any partial or pending word is lost.

Test Plan:
- Normal receive, LSB_FIRST=1, ready=1:
  - Stimulus: drive strobe 0..35 with serial_in=1 only at digits 0 and 35.
  - Required: word=36'h8_0000_0001; word_valid high exactly one cycle after the digit-35 cycle; no sync_err.
- Back-to-back words, ready=1:
  - Stimulus: two consecutive minor cycles carrying 36'h1_2345_6789 then 36'hF_EDCB_A987.
  - Required: two valid beats 36 cycles apart with matching values.
- Sync loss:
  - Stimulus: strobe all-zero at digit 17.
  - Required: sync_err pulses 1 cycle, state goes to HUNT, no word output for that cycle.
  - Stimulus continued: the next onehot(0) starts a new word, and the following full cycle delivers correctly.
- Resync on early digit 0:
  - Stimulus: onehot(0) arrives while exp=20.
  - Required: sync_err=1 and digit_idx=1 next cycle; the word completes 35 cycles later.
- Overrun:
  - Stimulus: word_ready=0 through two completions.
  - Required: the first word is held unchanged; overrun pulses at the second completion.
  - Stimulus continued: raising ready delivers the first word and word_valid then drops.
- Reset and enable:
  - Stimulus: rst_n low at digit 10.
  - Required: all outputs 0 asynchronously; reception restarts only at the next onehot(0).
  - Stimulus: enable low at digit 5.
  - Required: HUNT, no sync_err, pending word_valid retained.
